ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the same open-collector ps2clk/ps2data pair that the keyboard receiver listens on. It performs the request-to-send sequence, shifts out data, odd parity and stop bit on device-generated clock edges, and checks the device's acknowledge bit. The block sits beside the keyboard receiver in the top level. The top-level tristate buffers drive each line low when its `_oe` output is 1 and release it otherwise.

## Interface
Parameters:
- INHIBIT_CYCLES, 10000: ps2clk held low before the request (100 µs at 100 MHz).
- SETUP_CYCLES, 500: ps2data held low with ps2clk still low before ps2clk is released (5 µs).
- TIMEOUT_CYCLES, 2000000: limit from ps2clk release to frame end (20 ms).

Ports:
- clk_100MHz  in  1  system clock, single clock domain.
- reset  in  1  asynchronous, active-high.
- ps2clk_in  in  1  raw ps2clk pin level (asynchronous).
- ps2data_in  in  1  raw ps2data pin level (asynchronous).
- ps2clk_oe  out  1  1 = pull ps2clk low.
- ps2data_oe  out  1  1 = pull ps2data low.
- tx_data  in  8  command byte, sampled on accept.
- tx_start  in  1  request; accepted when busy=0.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at the end of every accepted transfer.
- ack_err  out  1  valid only with done; 1 = NACK or timeout.

## Operation
- Reset values: ps2clk_oe=0, ps2data_oe=0, busy=0, done=0, ack_err=0, FSM=IDLE.
- Assertion of reset releases both lines in the same cycle, including in the middle of a transfer.
- Frame is 11 bits: start(0), D0..D7 LSB first, odd parity (1 when D has an even number of ones), stop(1), then device ACK.
- States:
  - IDLE: both oe=0. When tx_start=1, latch tx_data, compute parity, busy←1, go to INHIBIT.
  - INHIBIT: ps2clk_oe=1 for INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: ps2clk_oe=1 and ps2data_oe=1 (start bit) for SETUP_CYCLES cycles. Then ps2clk_oe←0, clear the timeout counter, clear the bit index, go to SEND.
  - SEND: on each synchronized ps2clk falling edge, drive the bit at the current index onto the line (ps2data_oe = ~bit) and increment the index:
    - index 0–7: D0–D7.
    - index 8: parity.
    - index 9: stop bit, ps2data_oe=0.
    - After index 9, go to ACK.
  - ACK: on the next falling edge, sample synchronized ps2data. 0 = ACK, 1 = NACK (record it). Go to WAIT_IDLE.
  - WAIT_IDLE: wait until synchronized ps2clk=1 and ps2data=1 for one cycle, then go to IDLE. In that transition cycle: done=1, ack_err=recorded NACK, busy=0.
- Timeout: the counter runs in SEND, ACK and WAIT_IDLE. When it reaches TIMEOUT_CYCLES: both oe←0, done=1, ack_err=1, busy=0, go to IDLE.
- tx_start while busy=1 is ignored and not queued. tx_start in the done cycle is accepted, since busy is already 0.
- ps2clk_in and ps2data_in pass through 2-FF synchronizers. A falling edge is a registered-sync 1→0 transition.

## Timing
- From the accept edge: ps2clk_oe rises next cycle. ps2data_oe rises INHIBIT_CYCLES cycles later. ps2clk_oe falls a further SETUP_CYCLES cycles after that.
- Data update latency: ps2data_oe changes 3 clk_100MHz cycles after a pin falling edge (2 sync + 1 edge register). This is far below the device's ≥30 µs clock-low time.
- done/ack_err are exact one-cycle pulses. busy falls in the same cycle as done.
- Total frame at a 12.5 kHz device clock is about 1 ms.

## Structure
- Package ps2_pkg:
  - FSM state encodings: IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE.
  - Command constants: CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF, CMD_ECHO=8'hEE.
  - Default cycle-count constants.
- Sub-module ps2_line_sync: 2-FF synchronizer plus falling-edge detector, one instance per line. It is shared with the keyboard receiver.

## Test plan
For the bench, set INHIBIT_CYCLES=100, SETUP_CYCLES=10 and TIMEOUT_CYCLES=5000. The device model clocks with a 40-cycle half period, reads data on rising edges and drives ACK.
- tx_data=8'hED: bits 1,0,1,1,0,1,1,1, parity 1, stop 1 → ACK low → done=1, ack_err=0.
- tx_data=8'h01: parity 0, model sees the byte 0x01 → done=1, ack_err=0.
- Model leaves data high at ACK → done=1, ack_err=1; both oe=0 afterwards.
- Model never clocks → exactly 5000 cycles after ps2clk release: done=1, ack_err=1, busy=0.
- Reset asserted at bit 4 → ps2clk_oe=0, ps2data_oe=0, busy=0 in the same cycle. A new 8'hFF transfer then succeeds.
- tx_start pulsed mid-transfer → ignored, only one frame sent. tx_start in the done cycle → second frame starts next cycle.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, command bytes and default timing constants
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;

  localparam int DEF_INHIBIT_CYCLES = 10000;
  localparam int DEF_SETUP_CYCLES   = 500;
  localparam int DEF_TIMEOUT_CYCLES = 2000000;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-FF synchronizer and falling-edge detector for one PS/2 line
module ps2_line_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line,
  output logic o_sync,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Reset to 1 so an idle (pulled-up) line produces no spurious edge after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command transmitter with request-to-send and ACK check
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  localparam int CNT_W = $clog2((INHIBIT_CYCLES > SETUP_CYCLES ? INHIBIT_CYCLES : SETUP_CYCLES) + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  ps2_tx_state_e r_state;
  ps2_tx_state_e w_next;

  logic [CNT_W-1:0] r_cnt;
  logic [TMO_W-1:0] r_tmo;
  logic [3:0]       r_idx;
  logic [7:0]       r_shift;
  logic             r_par;
  logic             r_nack;
  logic             r_data_oe;

  logic w_clk_sync;
  logic w_clk_fall;
  logic w_data_sync;
  logic w_unused_data_fall;
  logic w_tmo_hit;
  logic w_idle_seen;
  logic w_done;
  logic w_accept;

  ps2_line_sync u_clk_sync (
    .i_clk  (clk_100MHz),
    .i_rst  (reset),
    .i_line (ps2clk_in),
    .o_sync (w_clk_sync),
    .o_fall (w_clk_fall)
  );

  ps2_line_sync u_data_sync (
    .i_clk  (clk_100MHz),
    .i_rst  (reset),
    .i_line (ps2data_in),
    .o_sync (w_data_sync),
    .o_fall (w_unused_data_fall)
  );

  assign w_tmo_hit   = (r_state == ST_SEND || r_state == ST_ACK || r_state == ST_WAIT_IDLE) &&
                       (r_tmo == TMO_W'(TIMEOUT_CYCLES));
  assign w_idle_seen = (r_state == ST_WAIT_IDLE) && w_clk_sync && w_data_sync;
  assign w_done      = w_tmo_hit | w_idle_seen;
  // busy already reads 0 in the done cycle, so a start there is taken immediately.
  assign w_accept    = tx_start && (r_state == ST_IDLE || w_done);

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (tx_start) w_next = ST_INHIBIT;
      ST_INHIBIT:   if (r_cnt == CNT_W'(INHIBIT_CYCLES - 1)) w_next = ST_REQ;
      ST_REQ:       if (r_cnt == CNT_W'(SETUP_CYCLES - 1)) w_next = ST_SEND;
      ST_SEND:      if (w_clk_fall && r_idx == 4'd9) w_next = ST_ACK;
      ST_ACK:       if (w_clk_fall) w_next = ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (w_idle_seen) w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
    if (w_tmo_hit) w_next = ST_IDLE;
    if (w_done && tx_start) w_next = ST_INHIBIT;
  end

  always_comb begin
    ps2clk_oe  = (r_state == ST_INHIBIT) || (r_state == ST_REQ);
    ps2data_oe = (r_state == ST_REQ) ||
                 ((r_state == ST_SEND || r_state == ST_ACK) && r_data_oe && !w_tmo_hit);
    busy       = (r_state != ST_IDLE) && !w_done;
    done       = w_done;
    ack_err    = w_tmo_hit || (w_idle_seen && r_nack);
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_tmo     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_nack    <= 1'b0;
      r_data_oe <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shift <= tx_data;
        r_par   <= odd_parity(tx_data);
        r_nack  <= 1'b0;
      end

      if (r_state != w_next)
        r_cnt <= '0;
      else if (r_state == ST_INHIBIT || r_state == ST_REQ)
        r_cnt <= r_cnt + 1'b1;

      // The start bit is held from REQ until the device's first falling edge.
      if (r_state == ST_REQ) begin
        r_tmo     <= '0;
        r_idx     <= '0;
        r_data_oe <= 1'b1;
      end else if (r_state == ST_SEND || r_state == ST_ACK || r_state == ST_WAIT_IDLE) begin
        r_tmo <= r_tmo + 1'b1;
      end

      if (r_state == ST_SEND && w_clk_fall) begin
        r_idx <= r_idx + 1'b1;
        if (r_idx < 4'd8)       r_data_oe <= ~r_shift[r_idx[2:0]];
        else if (r_idx == 4'd8) r_data_oe <= ~r_par;
        else                    r_data_oe <= 1'b0;
      end

      if (r_state == ST_ACK && w_clk_fall)
        r_nack <= w_data_sync;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a clocking PS/2 device model
module tb_ps2_host_tx;
  import ps2_pkg::*;

  logic       clk_100MHz = 1'b0;
  logic       reset      = 1'b1;
  logic [7:0] tx_data    = 8'h00;
  logic       tx_start   = 1'b0;
  logic       ps2clk_oe, ps2data_oe, busy, done, ack_err;
  logic       dev_clk    = 1'b1;
  logic       dev_data   = 1'b1;
  logic       ps2clk_line, ps2data_line;

  // Open-collector lines: either side may pull low.
  assign ps2clk_line  = dev_clk  & ~ps2clk_oe;
  assign ps2data_line = dev_data & ~ps2data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (100),
    .SETUP_CYCLES   (10),
    .TIMEOUT_CYCLES (5000)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .ps2clk_in  (ps2clk_line),
    .ps2data_in (ps2data_line),
    .ps2clk_oe  (ps2clk_oe),
    .ps2data_oe (ps2data_oe),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .busy       (busy),
    .done       (done),
    .ack_err    (ack_err)
  );

  initial forever #5 clk_100MHz = ~clk_100MHz;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_q[$];
  bit exp_e;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_100MHz) begin
    if (!reset && done) begin
      chk("done_single_cycle", {31'd0, prev_done}, 0);
      chk("busy_low_at_done", {31'd0, busy}, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_e = exp_q.pop_front();
        chk("ack_err", {31'd0, ack_err}, {31'd0, exp_e});
      end
    end
    prev_done = done;
  end

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk_100MHz);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk_100MHz);
    tx_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 4000) begin
      @(negedge clk_100MHz);
      n++;
    end
    chk({name, "_idle"}, {31'd0, busy}, 0);
  endtask

  // Device: waits for request-to-send, then 11 clock pulses; reads on rising edges, ACKs at pulse 11.
  task automatic dev_frame(input bit ack_low, input int abort_at,
                           output logic [7:0] d, output logic par, output logic stp, output bit aborted);
    int n = 0;
    logic [9:0] bits = '0;
    aborted = 1'b0;
    while (!(ps2clk_oe == 1'b0 && ps2data_oe == 1'b1) && n < 3000) begin
      @(posedge clk_100MHz);
      n++;
    end
    chk("dev_rts_seen", {31'd0, n < 3000}, 1);
    repeat (40) @(posedge clk_100MHz);
    for (int i = 0; i < 11; i++) begin
      dev_clk = 1'b0;
      if (i == abort_at) begin
        repeat (20) @(posedge clk_100MHz);
        aborted = 1'b1;
        break;
      end
      repeat (40) @(posedge clk_100MHz);
      dev_clk = 1'b1;
      if (i < 10) bits[i] = ps2data_line;
      if (i == 9 && ack_low) dev_data = 1'b0;
      if (i == 10) dev_data = 1'b1;
      if (i < 10) repeat (40) @(posedge clk_100MHz);
    end
    d   = bits[7:0];
    par = bits[8];
    stp = bits[9];
  endtask

  logic [7:0] rx_b;
  logic       rx_p, rx_s;
  bit         rx_ab;
  int         cnt;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_100MHz);
    chk("rst_clk_oe", {31'd0, ps2clk_oe}, 0);
    chk("rst_data_oe", {31'd0, ps2data_oe}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_ack_err", {31'd0, ack_err}, 0);
    reset = 1'b0;

    // 0xED with request-to-send timing
    exp_q.push_back(1'b0);
    start_tx(CMD_SET_LEDS);
    chk("t1_clk_oe_rise", {31'd0, ps2clk_oe}, 1);
    chk("t1_data_oe_low", {31'd0, ps2data_oe}, 0);
    chk("t1_busy", {31'd0, busy}, 1);
    cnt = 0;
    while (!ps2data_oe && cnt < 500) begin @(negedge clk_100MHz); cnt++; end
    chk("t1_inhibit_len", cnt, 100);
    cnt = 0;
    while (ps2clk_oe && cnt < 500) begin @(negedge clk_100MHz); cnt++; end
    chk("t1_setup_len", cnt, 10);
    dev_frame(1'b1, -1, rx_b, rx_p, rx_s, rx_ab);
    chk("t1_byte", {24'd0, rx_b}, 32'hED);
    chk("t1_parity", {31'd0, rx_p}, 1);
    chk("t1_stop", {31'd0, rx_s}, 1);
    wait_idle("t1");

    // 0x01, parity 0
    exp_q.push_back(1'b0);
    start_tx(8'h01);
    dev_frame(1'b1, -1, rx_b, rx_p, rx_s, rx_ab);
    chk("t2_byte", {24'd0, rx_b}, 32'h01);
    chk("t2_parity", {31'd0, rx_p}, 0);
    wait_idle("t2");

    // NACK
    exp_q.push_back(1'b1);
    start_tx(CMD_ECHO);
    dev_frame(1'b0, -1, rx_b, rx_p, rx_s, rx_ab);
    chk("t3_byte", {24'd0, rx_b}, 32'hEE);
    wait_idle("t3");
    @(negedge clk_100MHz);
    chk("t3_clk_oe_after", {31'd0, ps2clk_oe}, 0);
    chk("t3_data_oe_after", {31'd0, ps2data_oe}, 0);

    // Device never clocks: timeout
    exp_q.push_back(1'b1);
    start_tx(CMD_RESET);
    cnt = 0;
    while (ps2clk_oe && cnt < 500) begin @(negedge clk_100MHz); cnt++; end
    cnt = 0;
    while (!done && cnt < 6000) begin @(negedge clk_100MHz); cnt++; end
    chk("t4_timeout_cycles", cnt, 5000);
    chk("t4_busy_at_done", {31'd0, busy}, 0);
    chk("t4_data_oe_at_done", {31'd0, ps2data_oe}, 0);
    @(negedge clk_100MHz);
    chk("t4_busy_after", {31'd0, busy}, 0);
    chk("t4_clk_oe_after", {31'd0, ps2clk_oe}, 0);

    // Reset in the middle of bit 4 of 0x00
    start_tx(8'h00);
    dev_frame(1'b1, 4, rx_b, rx_p, rx_s, rx_ab);
    chk("t5_aborted", {31'd0, rx_ab}, 1);
    @(negedge clk_100MHz);
    chk("t5_busy_before", {31'd0, busy}, 1);
    chk("t5_data_oe_before", {31'd0, ps2data_oe}, 1);
    reset = 1'b1;
    #1;
    chk("t5_clk_oe_rst", {31'd0, ps2clk_oe}, 0);
    chk("t5_data_oe_rst", {31'd0, ps2data_oe}, 0);
    chk("t5_busy_rst", {31'd0, busy}, 0);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    @(negedge clk_100MHz);
    reset = 1'b0;
    exp_q.push_back(1'b0);
    start_tx(CMD_RESET);
    dev_frame(1'b1, -1, rx_b, rx_p, rx_s, rx_ab);
    chk("t5_byte", {24'd0, rx_b}, 32'hFF);
    chk("t5_parity", {31'd0, rx_p}, 1);
    wait_idle("t5");

    // tx_start while busy is ignored
    exp_q.push_back(1'b0);
    start_tx(8'h01);
    fork
      dev_frame(1'b1, -1, rx_b, rx_p, rx_s, rx_ab);
      begin
        repeat (600) @(negedge clk_100MHz);
        tx_data  = 8'hAA;
        tx_start = 1'b1;
        @(negedge clk_100MHz);
        tx_start = 1'b0;
        tx_data  = 8'h00;
      end
    join
    chk("t6_byte", {24'd0, rx_b}, 32'h01);
    wait_idle("t6");
    repeat (300) @(negedge clk_100MHz);
    chk("t6_no_second_busy", {31'd0, busy}, 0);
    chk("t6_no_second_clk_oe", {31'd0, ps2clk_oe}, 0);

    // tx_start in the done cycle starts the next frame immediately
    exp_q.push_back(1'b0);
    start_tx(CMD_SET_LEDS);
    fork
      dev_frame(1'b1, -1, rx_b, rx_p, rx_s, rx_ab);
      begin
        cnt = 0;
        while (!done && cnt < 3000) begin @(negedge clk_100MHz); cnt++; end
        chk("t7_done_seen", {31'd0, done}, 1);
        exp_q.push_back(1'b0);
        tx_data  = 8'h01;
        tx_start = 1'b1;
        @(negedge clk_100MHz);
        tx_start = 1'b0;
        chk("t7_second_clk_oe", {31'd0, ps2clk_oe}, 1);
        chk("t7_second_busy", {31'd0, busy}, 1);
      end
    join
    chk("t7_first_byte", {24'd0, rx_b}, 32'hED);
    dev_frame(1'b1, -1, rx_b, rx_p, rx_s, rx_ab);
    chk("t7_second_byte", {24'd0, rx_b}, 32'h01);
    wait_idle("t7");

    repeat (20) @(negedge clk_100MHz);
    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
